// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write-side (and future read-side) sinks:
// burst-type and response encodings plus the sink FSM state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } sink_state_e;

endpackage

// File: rtl/axi_burst_addr_next.sv
// Combinational AXI next-beat address calculator (FIXED / INCR / WRAP).
// All arithmetic wraps modulo 2^AW.
module axi_burst_addr_next
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] size_bytes;
  logic [AW-1:0] wrap_mask;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_addr;

  // INCR realigns after the first (possibly unaligned) beat; WRAP stays inside its window
  always_comb begin
    size_bytes = AW'(1) << size;
    wrap_mask  = ((AW'(len) + AW'(1)) << size) - AW'(1);
    incr_addr  = (addr & ~(size_bytes - AW'(1))) + size_bytes;
    wrap_addr  = (addr & ~wrap_mask) | ((addr + size_bytes) & wrap_mask);
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = wrap_addr;
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_write_burst_sink.sv
// AXI4 write burst sink: takes one AW, consumes the W beats as byte-strobed
// memory writes, then returns a single B response. One burst in flight.
module axi_write_burst_sink
  import axi_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 64,
  parameter int MAX_SIZE = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   s_axi_awaddr,
  input  logic [7:0]      s_axi_awlen,
  input  logic [2:0]      s_axi_awsize,
  input  logic [1:0]      s_axi_awburst,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [DW-1:0]   s_axi_wdata,
  input  logic [DW/8-1:0] s_axi_wstrb,
  input  logic            s_axi_wlast,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_ready
);

  sink_state_e   state_q, state_d;
  logic          awready_q, awready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [2:0]    size_q, size_d;
  logic [1:0]    burst_q, burst_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [AW-1:0] next_addr;
  logic [AW-1:0] aw_size_mask;
  logic [AW-1:0] aw_last_addr;
  logic          aw_len_wrap_ok;
  logic          aw_err;
  logic          beat;
  logic          last_beat;

  axi_burst_addr_next #(.AW(AW)) u_addr_next (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Legality check of the incoming AW request; any violation poisons the whole burst
  always_comb begin
    aw_size_mask   = (AW'(1) << s_axi_awsize) - AW'(1);
    aw_last_addr   = (s_axi_awaddr & ~aw_size_mask) + (AW'(s_axi_awlen) << s_axi_awsize);
    aw_len_wrap_ok = (s_axi_awlen == 8'd1) || (s_axi_awlen == 8'd3) ||
                     (s_axi_awlen == 8'd7) || (s_axi_awlen == 8'd15);
    aw_err = (s_axi_awsize > 3'(MAX_SIZE)) ||
             (s_axi_awburst == BURST_RSVD) ||
             ((s_axi_awburst == BURST_WRAP) && !aw_len_wrap_ok) ||
             ((s_axi_awburst == BURST_WRAP) && ((s_axi_awaddr & aw_size_mask) != '0)) ||
             ((s_axi_awburst == BURST_INCR) && (aw_last_addr[AW-1:12] != s_axi_awaddr[AW-1:12]));
  end

  // Next-state logic: AW latch, beat counting/address stepping, B handshake
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    beat      = (state_q == ST_DATA) && s_axi_wvalid && mem_ready;
    last_beat = (cnt_q == len_q);
    case (state_q)
      ST_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          addr_d  = s_axi_awaddr;
          len_d   = s_axi_awlen;
          size_d  = s_axi_awsize;
          burst_d = s_axi_awburst;
          cnt_d   = 8'd0;
          err_d   = aw_err;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          // The beat counter ends the burst; a disagreeing wlast only flags an error
          if (s_axi_wlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    awready_d = (state_d == ST_IDLE);
    bvalid_d  = (state_d == ST_RESP);
    bresp_d   = (state_d == ST_RESP) ? (err_d ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;
  end

  // State and handshake registers; reset abandons any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      err_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
    end
  end

  // Memory port mirrors the accepted beat in the same cycle; writes suppressed on error
  always_comb begin
    s_axi_awready = awready_q;
    s_axi_wready  = (state_q == ST_DATA) && mem_ready;
    s_axi_bvalid  = bvalid_q;
    s_axi_bresp   = bresp_q;
    mem_we        = beat && !err_q;
    mem_addr      = beat ? addr_q : '0;
    mem_wdata     = beat ? s_axi_wdata : '0;
    mem_wstrb     = beat ? s_axi_wstrb : '0;
  end

endmodule

// File: tb/tb_axi_write_burst_sink.sv
// Directed self-checking bench for axi_write_burst_sink.
module tb_axi_write_burst_sink;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_write_burst_sink #(.AW(32), .DW(64), .MAX_SIZE(3)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready)
  );

  // Timing: tasks start at posedge+1, sample at posedge+5, then move to next posedge+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, output bit ok);
    s_axi_awaddr = a; s_axi_awlen = l; s_axi_awsize = s; s_axi_awburst = b;
    s_axi_awvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #4;
      if (s_axi_awready) ok = 1'b1;
      step();
    end
    s_axi_awvalid = 1'b0;
    $display("AW addr=%h len=%0d size=%0d burst=%0d accepted=%0d", a, l, s, b, ok);
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] st, input logic l,
                            output logic we, output logic [31:0] a, output logic [63:0] wd,
                            output logic [7:0] ws, output int waited, output bit ok);
    s_axi_wdata = d; s_axi_wstrb = st; s_axi_wlast = l; s_axi_wvalid = 1'b1;
    ok = 1'b0; we = 1'b0; a = '0; wd = '0; ws = '0; waited = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #4;
      if (s_axi_wready) begin
        ok = 1'b1; we = mem_we; a = mem_addr; wd = mem_wdata; ws = mem_wstrb; waited = i;
      end
      step();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    $display("W  data=%h strb=%h last=%0d -> mem_we=%0d mem_addr=%h waited=%0d", d, st, l, we, a, waited);
  endtask

  task automatic wait_b(output logic [1:0] resp, output int waited, output bit ok);
    s_axi_bready = 1'b1;
    ok = 1'b0; resp = 2'bxx; waited = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #4;
      if (s_axi_bvalid) begin ok = 1'b1; resp = s_axi_bresp; waited = i; end
      step();
    end
    s_axi_bready = 1'b0;
    $display("B  bresp=%b waited=%0d seen=%0d", resp, waited, ok);
  endtask

  task automatic test_reset();
    s_axi_wvalid = 1'b1;
    repeat (2) step();
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, mem_we} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 64'h0 || mem_wstrb !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got aw=%b w=%b bv=%b br=%b we=%b addr=%h want all 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, mem_we, mem_addr);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (s_axi_awready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_awready_after got %b want 1", s_axi_awready);
    end
    vectors++;
    if (s_axi_wready !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_w_stall got wready=%b mem_we=%b want 0 0", s_axi_wready, mem_we);
    end
    s_axi_wvalid = 1'b0;
    $display("RESET released");
  endtask

  task automatic test_incr();
    logic [31:0] exp_a [4] = '{32'h1000, 32'h1008, 32'h1010, 32'h1018};
    logic we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; int waited; bit ok;
    logic [1:0] resp;
    drive_aw(32'h1000, 8'd3, 3'd3, BURST_INCR, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL incr_aw got accepted=%0d want 1", ok); end
    for (int i = 0; i < 4; i++) begin
      drive_beat(64'hA000_0000_0000_0000 + 64'(i), 8'hF0 | 8'(i), (i == 3), we, a, wd, ws, waited, ok);
      vectors++;
      if (ok !== 1'b1 || we !== 1'b1 || a !== exp_a[i] ||
          wd !== 64'hA000_0000_0000_0000 + 64'(i) || ws !== (8'hF0 | 8'(i))) begin
        miscompares++;
        $display("FAIL incr_beat%0d got ok=%0d we=%b addr=%h data=%h strb=%h want we=1 addr=%h",
                 i, ok, we, a, wd, ws, exp_a[i]);
      end
      if (i == 0) begin
        vectors++;
        if (waited !== 0) begin
          miscompares++;
          $display("FAIL incr_first_wready_latency got %0d want 0", waited);
        end
      end
    end
    wait_b(resp, waited, ok);
    vectors++;
    if (ok !== 1'b1 || resp !== RESP_OKAY || waited !== 0) begin
      miscompares++;
      $display("FAIL incr_bresp got seen=%0d bresp=%b waited=%0d want 1 00 0", ok, resp, waited);
    end
    vectors++;
    if (s_axi_awready !== 1'b1) begin
      miscompares++;
      $display("FAIL incr_awready_return got %b want 1", s_axi_awready);
    end
  endtask

  task automatic test_incr_unaligned();
    logic [31:0] exp_a [3] = '{32'h1003, 32'h1004, 32'h1008};
    logic we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; int waited; bit ok;
    logic [1:0] resp;
    drive_aw(32'h1003, 8'd2, 3'd2, BURST_INCR, ok);
    for (int i = 0; i < 3; i++) begin
      drive_beat(64'h55 + 64'(i), 8'h0F, (i == 2), we, a, wd, ws, waited, ok);
      vectors++;
      if (ok !== 1'b1 || we !== 1'b1 || a !== exp_a[i]) begin
        miscompares++;
        $display("FAIL unaligned_beat%0d got ok=%0d we=%b addr=%h want we=1 addr=%h", i, ok, we, a, exp_a[i]);
      end
    end
    wait_b(resp, waited, ok);
    vectors++;
    if (ok !== 1'b1 || resp !== RESP_OKAY) begin
      miscompares++;
      $display("FAIL unaligned_bresp got seen=%0d bresp=%b want 1 00", ok, resp);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4] = '{32'h2018, 32'h2000, 32'h2008, 32'h2010};
    logic we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; int waited; bit ok;
    logic [1:0] resp;
    drive_aw(32'h2018, 8'd3, 3'd3, BURST_WRAP, ok);
    for (int i = 0; i < 4; i++) begin
      drive_beat(64'hB0 + 64'(i), 8'hFF, (i == 3), we, a, wd, ws, waited, ok);
      vectors++;
      if (ok !== 1'b1 || we !== 1'b1 || a !== exp_a[i]) begin
        miscompares++;
        $display("FAIL wrap_beat%0d got ok=%0d we=%b addr=%h want we=1 addr=%h", i, ok, we, a, exp_a[i]);
      end
    end
    wait_b(resp, waited, ok);
    vectors++;
    if (ok !== 1'b1 || resp !== RESP_OKAY) begin
      miscompares++;
      $display("FAIL wrap_bresp got seen=%0d bresp=%b want 1 00", ok, resp);
    end
  endtask

  task automatic test_fixed_backpressure();
    logic we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; int waited; bit ok;
    logic [1:0] resp;
    drive_aw(32'h30, 8'd2, 3'd2, BURST_FIXED, ok);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        mem_ready = 1'b0;
        s_axi_wdata = 64'hC1; s_axi_wstrb = 8'h0F; s_axi_wvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
          #4;
          vectors++;
          if (s_axi_wready !== 1'b0 || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL fixed_stall%0d got wready=%b mem_we=%b want 0 0", k, s_axi_wready, mem_we);
          end
          step();
        end
        mem_ready = 1'b1;
      end
      drive_beat(64'hC0 + 64'(i), 8'h0F, (i == 2), we, a, wd, ws, waited, ok);
      vectors++;
      if (ok !== 1'b1 || we !== 1'b1 || a !== 32'h30 || wd !== 64'hC0 + 64'(i)) begin
        miscompares++;
        $display("FAIL fixed_beat%0d got ok=%0d we=%b addr=%h data=%h want we=1 addr=00000030 data=%h",
                 i, ok, we, a, wd, 64'hC0 + 64'(i));
      end
    end
    wait_b(resp, waited, ok);
    vectors++;
    if (ok !== 1'b1 || resp !== RESP_OKAY) begin
      miscompares++;
      $display("FAIL fixed_bresp got seen=%0d bresp=%b want 1 00", ok, resp);
    end
  endtask

  task automatic test_illegal_aw();
    logic [31:0] addrs [3] = '{32'h0, 32'h40, 32'hFF8};
    logic [2:0]  sizes [3] = '{3'd4, 3'd3, 3'd3};
    logic [1:0]  bursts [3] = '{BURST_INCR, BURST_RSVD, BURST_INCR};
    logic we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; int waited; bit ok;
    logic [1:0] resp;
    for (int c = 0; c < 3; c++) begin
      drive_aw(addrs[c], 8'd1, sizes[c], bursts[c], ok);
      for (int i = 0; i < 2; i++) begin
        drive_beat(64'hDEAD, 8'hFF, (i == 1), we, a, wd, ws, waited, ok);
        vectors++;
        if (ok !== 1'b1 || we !== 1'b0) begin
          miscompares++;
          $display("FAIL illegal%0d_beat%0d got ok=%0d mem_we=%b want consumed with mem_we=0", c, i, ok, we);
        end
      end
      wait_b(resp, waited, ok);
      vectors++;
      if (ok !== 1'b1 || resp !== RESP_SLVERR) begin
        miscompares++;
        $display("FAIL illegal%0d_bresp got seen=%0d bresp=%b want 1 10", c, ok, resp);
      end
    end
  endtask

  task automatic test_wlast_error_hold();
    logic exp_we [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; int waited; bit ok;
    logic [1:0] resp;
    drive_aw(32'h500, 8'd3, 3'd3, BURST_INCR, ok);
    for (int i = 0; i < 4; i++) begin
      drive_beat(64'hE0 + 64'(i), 8'hFF, (i == 1), we, a, wd, ws, waited, ok);
      vectors++;
      if (ok !== 1'b1 || we !== exp_we[i]) begin
        miscompares++;
        $display("FAIL wlast_beat%0d got ok=%0d mem_we=%b want consumed mem_we=%b", i, ok, we, exp_we[i]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      #4;
      vectors++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== RESP_SLVERR || s_axi_wready !== 1'b0 || s_axi_awready !== 1'b0) begin
        miscompares++;
        $display("FAIL bhold%0d got bvalid=%b bresp=%b wready=%b awready=%b want 1 10 0 0",
                 k, s_axi_bvalid, s_axi_bresp, s_axi_wready, s_axi_awready);
      end
      step();
    end
    wait_b(resp, waited, ok);
    vectors++;
    if (ok !== 1'b1 || resp !== RESP_SLVERR) begin
      miscompares++;
      $display("FAIL wlast_bresp got seen=%0d bresp=%b want 1 10", ok, resp);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic we; logic [31:0] a; logic [63:0] wd; logic [7:0] ws; int waited; bit ok;
    logic [1:0] resp;
    drive_aw(32'h4000, 8'd7, 3'd3, BURST_INCR, ok);
    for (int i = 0; i < 2; i++) drive_beat(64'hF0 + 64'(i), 8'hFF, 1'b0, we, a, wd, ws, waited, ok);
    s_axi_wdata = 64'hF2; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
    #2;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h4010) begin
      miscompares++;
      $display("FAIL rst_mid_third_beat got we=%b addr=%h want 1 00004010", mem_we, mem_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, mem_we} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 64'h0 || mem_wstrb !== 8'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got aw=%b w=%b bv=%b we=%b addr=%h want all 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, mem_we, mem_addr);
    end
    step();
    rst = 1'b0;
    s_axi_wvalid = 1'b0;
    step();
    vectors++;
    if (s_axi_awready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_recover got awready=%b bvalid=%b want 1 0", s_axi_awready, s_axi_bvalid);
    end
    $display("RESET mid-burst released");
    drive_aw(32'h100, 8'd1, 3'd3, BURST_INCR, ok);
    for (int i = 0; i < 2; i++) begin
      drive_beat(64'h11 + 64'(i), 8'hFF, (i == 1), we, a, wd, ws, waited, ok);
      vectors++;
      if (ok !== 1'b1 || we !== 1'b1 || a !== 32'h100 + 32'(8 * i)) begin
        miscompares++;
        $display("FAIL post_rst_beat%0d got ok=%0d we=%b addr=%h want 1 %h", i, ok, we, a, 32'h100 + 32'(8 * i));
      end
    end
    wait_b(resp, waited, ok);
    vectors++;
    if (ok !== 1'b1 || resp !== RESP_OKAY) begin
      miscompares++;
      $display("FAIL post_rst_bresp got seen=%0d bresp=%b want 1 00", ok, resp);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_incr();
    test_incr_unaligned();
    test_wrap();
    test_fixed_backpressure();
    test_illegal_aw();
    test_wlast_error_hold();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
